debug_run_ctrl: RTL
===================

// Module: debug_run_ctrl
// PURPOSE
// - Debug run-control sequencer for the Game Boy core: decodes UART command bytes into run/pause/step of gb clock.
// - Sits between uart_rx and the gb clock-enable gate; emits a one-clk trigger pulse on each entry to PAUSED.
// - Acks every command byte via a 1-deep ready/valid port, for uart_tx.
// PARAMETERS
// - STEP_DEFAULT  4  gb ticks per "s" step after reset (1..256; 256 encoded as 8'd0)
// PORTS
// - clk          in   1  system clock; all logic on posedge clk
// - rst_n        in   1  reset, asynchronous, active-low
// - rx_valid     in   1  one-clk strobe: rx_byte holds a new byte
// - rx_byte      in   8  received command byte
// - gb_tick      in   1  one-clk pulse per gb_clk rising edge, already in clk domain
// - halt         in   1  CPU HALT status, level, clk domain
// - run_en       out  1  gb clock enable; 1 in RUNNING and STEPPING
// - trigger      out  1  one-clk pulse on every transition into PAUSED
// - ack_valid    out  1  ack byte pending
// - ack_byte     out  8  ack code
// - ack_ready    in   1  consumer accepts ack when ack_valid && ack_ready
// - ack_ovf      out  1  sticky: an ack was dropped while one was pending
// BEHAVIOUR
// - Reset: state PAUSED, parse IDLE, run_en 0, trigger 0, step_len = STEP_DEFAULT, ack_valid 0, ack_byte 0, ack_ovf 0.
// - All outputs registered; a command byte on cycle N takes effect (run_en, trigger, ack) on cycle N+1.
// - States: PAUSED, RUNNING, STEPPING; run_en = (state != PAUSED).
// - Commands (parse IDLE):
//   - "r": go to RUNNING from any state.
//   - "p": go to PAUSED.
//   - "s": load step_cnt = step_len and go to STEPPING; re-issue while stepping restarts the count.
//   - "c": parse -> ARG; the next rx byte is stored as step_len (8'd0 = 256) and parse -> IDLE.
//   - Anything else: no state change, ack "?".
// - The ARG byte is never interpreted as a command.
// - Ack:
//   - On each accepted command or ARG byte, ack_byte = that byte, or "?" if unknown; ack_valid = 1.
//   - ack_valid holds until ack_valid && ack_ready.
//   - New ack while one is pending and not accepted this cycle: the old ack is overwritten and ack_ovf is set.
//   - Commands are never stalled by ack backpressure.
// - STEPPING:
//   - Each gb_tick decrements step_cnt.
//   - gb_tick with step_cnt == 1 -> PAUSED with a trigger pulse; exactly step_len ticks see run_en = 1.
//   - step_cnt is 9 bits so that 256 is representable.
// - Trigger: pulses when the next state is PAUSED and the current state is not.
//   - "p" while PAUSED gives no pulse but is still acked.
// - Simultaneous events: rx command and step completion in the same cycle -> the command's transition wins.
//   - Example: "r" during the final tick leaves the block RUNNING, no trigger.
//   - "p" in that cycle gives exactly one trigger pulse.
// - Reset mid-step or mid-ARG: everything returns to reset values immediately; the pending ARG is discarded.
// CONFIGURATION
// - DEBUG_HALT_BREAK_EN defined:
//   - A registered rising edge of halt while RUNNING or STEPPING forces PAUSED, pulses trigger, and acks "h".
//   - An rx command in the same cycle wins, as above.
// - DEBUG_HALT_BREAK_EN undefined: halt is ignored; the port remains for a stable interface.
// STRUCTURE
// - Package dbg_run_pkg: state encodings (PAUSED/RUNNING/STEPPING), parse states (IDLE/ARG), and byte constants:
//   - CMD_RUN "r", CMD_PAUSE "p", CMD_STEP "s", CMD_CNT "c", ACK_ERR "?", ACK_HALT "h".
// - One sub-module, dbg_ack_slot: 1-deep ready/valid holding register with overflow flag.
// TESTING
// - Reset, then "s" with 4 gb_ticks spaced 3 clk -> run_en high for exactly 4 ticks; one trigger; ack "s".
// - "c", 8'd0, "s", then 300 ticks -> PAUSED after the 256th tick; acks "c", 8'h00, "s".
// - "r", 10 ticks, "p" -> run_en 1 then 0 the cycle after "p"; single trigger; a second "p" gives no trigger.
// - "s" with rx "r" on the final-tick cycle -> RUNNING, no trigger.
// - ack_ready held 0 across "r" then "x" -> ack_byte "?", ack_ovf 1; ack_ready 1 -> ack_valid falls; ack_ovf stays set.
// - DEBUG_HALT_BREAK_EN: RUNNING, halt rises -> PAUSED, trigger, ack "h".
//   - Without the macro: stays RUNNING.
//   - rst_n low mid-step -> run_en 0 asynchronously.

Source files
------------

// File: rtl/dbg_run_pkg.sv
// Shared types and byte codes for the debug run-control sequencer.
// Optional halt-break feature is enabled with DEBUG_HALT_BREAK_EN.
package dbg_run_pkg;

   typedef enum logic [1:0] {
      ST_PAUSED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } run_state_e;

   typedef enum logic {
      PS_IDLE = 1'b0,
      PS_ARG  = 1'b1
   } parse_state_e;

   localparam logic [7:0] CMD_RUN   = 8'h72;
   localparam logic [7:0] CMD_PAUSE = 8'h70;
   localparam logic [7:0] CMD_STEP  = 8'h73;
   localparam logic [7:0] CMD_CNT   = 8'h63;
   localparam logic [7:0] ACK_ERR   = 8'h3F;
   localparam logic [7:0] ACK_HALT  = 8'h68;

   // A stored length of zero stands for a 256-tick step.
   function automatic logic [8:0] step_load(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Ack port bundle: 1-deep ready/valid byte channel plus overflow flag.
// The producer side is the master, the consumer (uart_tx) the slave.
interface debug_run_ctrl_if;
   logic       valid;
   logic [7:0] data;
   logic       ready;
   logic       ovf;

   modport master (output valid, output data, output ovf, input ready);
   modport slave  (input valid, input data, input ovf, output ready);
endinterface

// File: rtl/dbg_ack_slot.sv
// Single-entry ack holding register; a push never stalls, it
// overwrites a pending unaccepted ack and records that in a sticky flag.
module dbg_ack_slot (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [7:0]       data_i,
   debug_run_ctrl_if.master ack
);

   logic       valid_q, valid_d;
   logic [7:0] data_q, data_d;
   logic       ovf_q, ovf_d;

   // Next-state: load on push, clear on handshake, flag overwrites.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      if (push_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         if (valid_q && !ack.ready) begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && ack.ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= 8'd0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ack.valid = valid_q;
   assign ack.data  = data_q;
   assign ack.ovf   = ovf_q;

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run-control: UART command bytes drive run/pause/step of gb clock.
// Define DEBUG_HALT_BREAK_EN to pause on a rising CPU halt.
module debug_run_ctrl
   import dbg_run_pkg::*;
#(
   parameter int STEP_DEFAULT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic       gb_tick,
   input  logic       halt,
   output logic       run_en,
   output logic       trigger,
   output logic       ack_valid,
   output logic [7:0] ack_byte,
   input  logic       ack_ready,
   output logic       ack_ovf
);

   run_state_e   state_q, state_d;
   parse_state_e parse_q, parse_d;
   logic [7:0]   step_len_q, step_len_d;
   logic [8:0]   step_cnt_q, step_cnt_d;
   logic         run_en_q;
   logic         trig_q, trig_d;
   logic         ack_push;
   logic [7:0]   ack_data;
   logic         halt_rise;

`ifdef DEBUG_HALT_BREAK_EN
   logic halt_q, halt_qq;

   // Two-stage halt register; the edge is taken between the stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_q  <= 1'b0;
         halt_qq <= 1'b0;
      end else begin
         halt_q  <= halt;
         halt_qq <= halt_q;
      end
   end

   assign halt_rise = halt_q && !halt_qq;
`else
   logic unused_halt;
   assign unused_halt = halt;
   assign halt_rise   = 1'b0;
`endif

   // Next-state: step countdown, halt break, then rx overrides both.
   always_comb begin
      state_d    = state_q;
      parse_d    = parse_q;
      step_len_d = step_len_q;
      step_cnt_d = step_cnt_q;
      ack_push   = 1'b0;
      ack_data   = 8'd0;

      if (state_q == ST_STEPPING && gb_tick) begin
         step_cnt_d = step_cnt_q - 9'd1;
         if (step_cnt_q == 9'd1) begin
            state_d = ST_PAUSED;
         end
      end

      if (state_q != ST_PAUSED && halt_rise) begin
         state_d  = ST_PAUSED;
         ack_push = 1'b1;
         ack_data = ACK_HALT;
      end

      if (rx_valid) begin
         ack_push = 1'b1;
         ack_data = rx_byte;
         if (parse_q == PS_ARG) begin
            step_len_d = rx_byte;
            parse_d    = PS_IDLE;
         end else begin
            unique case (1'b1)
               rx_byte == CMD_RUN:   state_d = ST_RUNNING;
               rx_byte == CMD_PAUSE: state_d = ST_PAUSED;
               rx_byte == CMD_STEP: begin
                  state_d    = ST_STEPPING;
                  step_cnt_d = step_load(step_len_q);
               end
               rx_byte == CMD_CNT:   parse_d  = PS_ARG;
               default:              ack_data = ACK_ERR;
            endcase
         end
      end

      trig_d = (state_d == ST_PAUSED) && (state_q != ST_PAUSED);
   end

   // Control state and registered run/trigger outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_PAUSED;
         parse_q    <= PS_IDLE;
         step_len_q <= 8'(STEP_DEFAULT);
         step_cnt_q <= 9'd0;
         run_en_q   <= 1'b0;
         trig_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         parse_q    <= parse_d;
         step_len_q <= step_len_d;
         step_cnt_q <= step_cnt_d;
         run_en_q   <= (state_d != ST_PAUSED);
         trig_q     <= trig_d;
      end
   end

   debug_run_ctrl_if ack_if ();

   dbg_ack_slot u_ack (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (ack_push),
      .data_i (ack_data),
      .ack    (ack_if)
   );

   assign ack_if.ready = ack_ready;
   assign ack_valid    = ack_if.valid;
   assign ack_byte     = ack_if.data;
   assign ack_ovf      = ack_if.ovf;
   assign run_en       = run_en_q;
   assign trigger      = trig_q;

endmodule
